// File: rtl/ram_interface_if.sv
// Bus between the control unit and the RAM stage: request/address/data in,
// registered read data and the busy/done/addr_err status back.
interface ram_interface_if;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr_in;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic        addr_err;

    modport master (
        output mem_read, mem_write, addr_in, wdata,
        input  rdata, busy, done, addr_err
    );

    modport slave (
        input  mem_read, mem_write, addr_in, wdata,
        output rdata, busy, done, addr_err
    );
endinterface

// File: rtl/ram_interface.sv
// Word-addressed RAM stage with WAIT_STATES wait cycles and a one-cycle done pulse.
// Define RAM_ADDR_CHECK_EN to flag requests with nonzero addr_in[31:ADDR_BITS] as errors.
//
// state | meaning
// IDLE  | accepting a single read or write request
// WAIT  | counting down wait states; access performed when the counter hits 0
// DONE  | one-cycle completion pulse (addr_err alongside for rejected requests)
module ram_interface #(
    parameter int ADDR_BITS   = 9,
    parameter int WAIT_STATES = 1
) (
    input  logic            clk,
    input  logic            clr,
    ram_interface_if.slave  bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

    logic [1:0]           r_state;
    logic [3:0]           r_cnt;
    logic [ADDR_BITS-1:0] r_addr;
    logic [31:0]          r_wdata;
    logic [31:0]          r_rdata;
    logic                 r_op_write;
    logic                 r_err;
    logic [31:0]          r_mem [2**ADDR_BITS];

    logic w_req_single;
    logic w_req_both;
    logic w_addr_bad;
    logic w_access;

    assign w_req_single = bus.mem_read ^ bus.mem_write;
    assign w_req_both   = bus.mem_read & bus.mem_write;

`ifdef RAM_ADDR_CHECK_EN
    assign w_addr_bad = |bus.addr_in[31:ADDR_BITS];
`else
    // Upper address bits are don't-care: addresses wrap modulo the array depth.
    logic w_unused_addr_hi;
    assign w_unused_addr_hi = |bus.addr_in[31:ADDR_BITS];
    assign w_addr_bad       = 1'b0;
`endif

    assign w_access = (r_state == S_WAIT) && (r_cnt == 4'd0) && !r_err;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_addr     <= '0;
            r_wdata    <= 32'd0;
            r_rdata    <= 32'd0;
            r_op_write <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req_single || w_req_both) begin
                        r_addr     <= bus.addr_in[ADDR_BITS-1:0];
                        r_wdata    <= bus.wdata;
                        r_op_write <= bus.mem_write;
                        r_err      <= w_req_both || w_addr_bad;
                        r_cnt      <= WS_LOAD;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        if (w_access && !r_op_write) begin
                            r_rdata <= r_mem[r_addr];
                        end
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Array has no reset; clr only has to suppress an in-flight write.
    always_ff @(posedge clk) begin
        if (!clr && w_access && r_op_write) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

    assign bus.rdata    = r_rdata;
    assign bus.busy     = (r_state == S_WAIT);
    assign bus.done     = (r_state == S_DONE);
    assign bus.addr_err = (r_state == S_DONE) && r_err;

endmodule

// File: tb/tb_ram_interface.sv
// Randomized bench for ram_interface against an array-based reference model,
// plus latency/throughput sweeps on WAIT_STATES = 0 and 15 instances.
module tb_ram_interface;

    localparam int AB = 9;
    localparam int WS = 1;
`ifdef RAM_ADDR_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic clr;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_interface_if bus ();
    ram_interface_if b0 ();
    ram_interface_if b15 ();

    ram_interface #(.ADDR_BITS(AB), .WAIT_STATES(WS)) dut    (.clk(clk), .clr(clr), .bus(bus));
    ram_interface #(.ADDR_BITS(AB), .WAIT_STATES(0))  u_ws0  (.clk(clk), .clr(clr), .bus(b0));
    ram_interface #(.ADDR_BITS(AB), .WAIT_STATES(15)) u_ws15 (.clk(clk), .clr(clr), .bus(b15));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: array contents and the last successfully read word.
    logic [31:0] mdl_mem [int];
    logic [31:0] mdl_rdata;

    function automatic logic mdl_is_err(input logic rd, input logic wr, input logic [31:0] a);
        logic [31:0] hi;
        hi = a >> AB;
        return (rd && wr) || (CHECK_EN && hi != 32'd0);
    endfunction

    task automatic run_op(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input string tag);
        int   lat;
        int   nbusy;
        int   idx;
        logic seen;
        logic err;
        err = mdl_is_err(rd, wr, a);
        idx = int'(a[AB-1:0]);
        if (!err) begin
            if (wr) mdl_mem[idx] = d;
            else if (mdl_mem.exists(idx)) mdl_rdata = mdl_mem[idx];
        end
        @(negedge clk);
        bus.mem_read  = rd;
        bus.mem_write = wr;
        bus.addr_in   = a;
        bus.wdata     = d;
        @(posedge clk);
        #1;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        lat = 0; nbusy = 0; seen = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (bus.done) seen = 1'b1;
            else if (bus.busy) nbusy++;
        end
        check({tag, " done_seen"},   32'(seen), 32'd1);
        check({tag, " latency"},     32'(lat - 1), 32'(WS + 1));
        check({tag, " busy_cycles"}, 32'(nbusy), 32'(WS + 1));
        check({tag, " busy_at_done"}, 32'(bus.busy), 32'd0);
        check({tag, " addr_err"},    32'(bus.addr_err), 32'(err));
        check({tag, " rdata"},       bus.rdata, mdl_rdata);
        @(negedge clk);
        check({tag, " done_pulse_end"}, 32'(bus.done), 32'd0);
    endtask

    task automatic count_dones(input int n, output int ndone);
        ndone = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          ndone;
        int          start;
        int          n0, n15;
        int          d0 [2];
        int          d15 [2];
        logic [31:0] pool [8];
        logic [31:0] a;
        logic [31:0] d;
        int          kind;

        clr = 1'b1;
        bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.addr_in = '0; bus.wdata = '0;
        b0.mem_read  = 1'b0; b0.mem_write  = 1'b0; b0.addr_in  = '0; b0.wdata  = '0;
        b15.mem_read = 1'b0; b15.mem_write = 1'b0; b15.addr_in = '0; b15.wdata = '0;
        mdl_rdata = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset rdata",    bus.rdata, 32'd0);
        check("reset busy",     32'(bus.busy), 32'd0);
        check("reset done",     32'(bus.done), 32'd0);
        check("reset addr_err", 32'(bus.addr_err), 32'd0);
        clr = 1'b0;

        run_op(1'b0, 1'b1, 32'h010, 32'hDEADBEEF, "wr010");
        run_op(1'b0, 1'b1, 32'h1FF, 32'h12345678, "wr1ff");
        run_op(1'b1, 1'b0, 32'h1FF, 32'h0,        "rd1ff");
        run_op(1'b0, 1'b1, 32'h000, 32'hAAAAAAAA, "wr000_hold");
        run_op(1'b1, 1'b1, 32'h1FF, 32'h0BADF00D, "both_err");
        run_op(1'b1, 1'b0, 32'h1FF, 32'h0,        "rd1ff_after_err");

        // Read raised while busy with a write must be dropped.
        mdl_mem[32'h40] = 32'h40404040;
        @(negedge clk);
        bus.mem_write = 1'b1; bus.addr_in = 32'h40; bus.wdata = 32'h40404040;
        @(posedge clk);
        #1 bus.mem_write = 1'b0;
        @(negedge clk);
        bus.mem_read = 1'b1; bus.addr_in = 32'h1FF;
        @(negedge clk);
        bus.mem_read = 1'b0;
        count_dones(10, ndone);
        check("overlap done_count", 32'(ndone), 32'd1);
        run_op(1'b1, 1'b0, 32'h040, 32'h0, "rd040");

        run_op(1'b0, 1'b1, 32'h003,      32'h00000077, "wr003");
        run_op(1'b0, 1'b1, 32'h00000203, 32'h00000055, "wr203");
        run_op(1'b1, 1'b0, 32'h003,      32'h0,        "rd003");
        run_op(1'b1, 1'b0, 32'h00000200, 32'h0,        "rd200");

        // clr during the WAIT cycle of a write.
        run_op(1'b0, 1'b1, 32'h020, 32'h11111111, "wr020_prior");
        @(negedge clk);
        bus.mem_write = 1'b1; bus.addr_in = 32'h020; bus.wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1 bus.mem_write = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        mdl_rdata = 32'd0;
        check("clr_mid busy",  32'(bus.busy), 32'd0);
        check("clr_mid done",  32'(bus.done), 32'd0);
        check("clr_mid rdata", bus.rdata, 32'd0);
        count_dones(6, ndone);
        check("clr_mid no_done", 32'(ndone), 32'd0);
        run_op(1'b1, 1'b0, 32'h020, 32'h0, "rd020_after_clr");

        // clr and a request at the same edge: the request is lost.
        @(negedge clk);
        clr = 1'b1; bus.mem_read = 1'b1; bus.addr_in = 32'h1FF;
        @(negedge clk);
        clr = 1'b0; bus.mem_read = 1'b0;
        mdl_rdata = 32'd0;
        check("clr_req busy", 32'(bus.busy), 32'd0);
        count_dones(5, ndone);
        check("clr_req no_done", 32'(ndone), 32'd0);

        for (int i = 0; i < 8; i++) begin
            pool[i] = 32'($urandom_range(0, (1 << AB) - 1));
            run_op(1'b0, 1'b1, pool[i], $urandom, "rnd_init");
        end
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 9);
            a = pool[$urandom_range(0, 7)];
            if ($urandom_range(0, 3) == 0) a = a | (32'($urandom_range(1, 1000)) << AB);
            d = $urandom;
            if (kind == 0)     run_op(1'b1, 1'b1, a, d, "rnd_both");
            else if (kind < 5) run_op(1'b0, 1'b1, a, d, "rnd_wr");
            else               run_op(1'b1, 1'b0, a, d, "rnd_rd");
        end

        // Back-to-back reads on the WAIT_STATES = 0 and 15 instances.
        @(negedge clk);
        b0.mem_read = 1'b1; b15.mem_read = 1'b1;
        start = cyc;
        n0 = 0; n15 = 0;
        d0[0] = -100; d0[1] = -100; d15[0] = -100; d15[1] = -100;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (b0.done && n0 < 2)   begin d0[n0] = cyc;   n0++;  end
            if (b15.done && n15 < 2) begin d15[n15] = cyc; n15++; end
        end
        b0.mem_read = 1'b0; b15.mem_read = 1'b0;
        check("ws0 latency",  32'(d0[0] - (start + 1)),  32'd1);
        check("ws0 period",   32'(d0[1] - d0[0]),        32'd3);
        check("ws15 latency", 32'(d15[0] - (start + 1)), 32'd16);
        check("ws15 period",  32'(d15[1] - d15[0]),      32'd18);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
